// File: rtl/glitch_pulse_sequencer.sv
// glitch_pulse_sequencer: armed trigger-edge to delayed glitch pulse train.
// Optional arm-to-trigger timeout enabled by defining GLITCH_TRIG_TIMEOUT_EN.
module glitch_pulse_sequencer #(
   parameter int DELAY_W        = 32,
   parameter int WIDTH_W        = 16,
   parameter int REP_W          = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm_i,
   input  logic               abort_i,
   input  logic               trigger_i,
   input  logic [1:0]         edge_sel_i,
   input  logic [DELAY_W-1:0] delay_i,
   input  logic [WIDTH_W-1:0] width_i,
   input  logic [WIDTH_W-1:0] gap_i,
   input  logic [REP_W-1:0]   repeat_i,
   output logic               pulse_o,
   output logic               armed_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               timeout_o
);

   localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   trig_s;
   logic                   rise;
   logic                   fall;
   logic                   edge_hit;
   logic                   arm_ok;

   logic [1:0]         cfg_edge;
   logic [DELAY_W-1:0] cfg_delay;
   logic [WIDTH_W-1:0] cfg_width;
   logic [WIDTH_W-1:0] cfg_gap;
   logic [REP_W-1:0]   cfg_rep;

   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] width_ld;
   logic [CNT_W-1:0] gap_ld;
   logic [REP_W-1:0] rep, rep_n;

`ifdef GLITCH_TRIG_TIMEOUT_EN
   logic [31:0] tcnt, tcnt_n;
   logic        to_n;
   logic        timeout_q;
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign trig_s   = sync_q[SYNC_STAGES-1];
   assign rise     = trig_s & ~edge_q;
   assign fall     = ~trig_s & edge_q;
   assign arm_ok   = (state == S_IDLE) && arm_i && !abort_i;
   assign width_ld = (cfg_width == '0) ? CNT_W'(1) : CNT_W'(cfg_width);
   assign gap_ld   = (cfg_gap == '0) ? CNT_W'(1) : CNT_W'(cfg_gap);

   always_comb begin
      edge_hit = rise;
      case (cfg_edge)
         2'b01:   edge_hit = fall;
         2'b10:   edge_hit = rise | fall;
         default: edge_hit = rise;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rep_n   = rep;
`ifdef GLITCH_TRIG_TIMEOUT_EN
      tcnt_n  = tcnt;
      to_n    = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            if (arm_ok) begin
               state_n = S_ARMED;
`ifdef GLITCH_TRIG_TIMEOUT_EN
               tcnt_n  = '0;
`endif
            end
         end
         S_ARMED: begin
            if (edge_hit) begin
               rep_n = (cfg_rep == '0) ? REP_W'(1) : cfg_rep;
               if (cfg_delay == '0) begin
                  state_n = S_PULSE;
                  cnt_n   = width_ld;
               end else begin
                  state_n = S_DELAY;
                  cnt_n   = CNT_W'(cfg_delay);
               end
            end
`ifdef GLITCH_TRIG_TIMEOUT_EN
            else if (tcnt >= 32'(TIMEOUT_CYCLES - 1)) begin
               state_n = S_IDLE;
               to_n    = 1'b1;
            end else begin
               tcnt_n = tcnt + 32'd1;
            end
`endif
         end
         S_DELAY: begin
            if (cnt <= CNT_W'(1)) begin
               state_n = S_PULSE;
               cnt_n   = width_ld;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (cnt > CNT_W'(1)) begin
               cnt_n = cnt - CNT_W'(1);
            end else if (rep <= REP_W'(1)) begin
               state_n = S_DONE;
            end else begin
               state_n = S_GAP;
               cnt_n   = gap_ld;
               rep_n   = rep - REP_W'(1);
            end
         end
         S_GAP: begin
            if (cnt <= CNT_W'(1)) begin
               state_n = S_PULSE;
               cnt_n   = width_ld;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // abort beats every other transition, including a same-cycle arm
      if (abort_i && state != S_IDLE) begin
         state_n = S_IDLE;
`ifdef GLITCH_TRIG_TIMEOUT_EN
         to_n    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sync_q    <= '0;
         edge_q    <= 1'b0;
         cfg_edge  <= '0;
         cfg_delay <= '0;
         cfg_width <= '0;
         cfg_gap   <= '0;
         cfg_rep   <= '0;
         cnt       <= '0;
         rep       <= '0;
         pulse_o   <= 1'b0;
         armed_o   <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
`ifdef GLITCH_TRIG_TIMEOUT_EN
         tcnt      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
         edge_q <= trig_s;
         cnt    <= cnt_n;
         rep    <= rep_n;
         if (arm_ok) begin
            cfg_edge  <= edge_sel_i;
            cfg_delay <= delay_i;
            cfg_width <= width_i;
            cfg_gap   <= gap_i;
            cfg_rep   <= repeat_i;
         end
         pulse_o <= (state_n == S_PULSE);
         armed_o <= (state_n == S_ARMED);
         busy_o  <= (state_n == S_ARMED) || (state_n == S_DELAY) ||
                    (state_n == S_PULSE) || (state_n == S_GAP);
         done_o  <= (state_n == S_DONE);
`ifdef GLITCH_TRIG_TIMEOUT_EN
         tcnt      <= tcnt_n;
         timeout_q <= to_n;
`endif
      end
   end

endmodule

// File: tb/tb_glitch_pulse_sequencer.sv
// tb_glitch_pulse_sequencer: vector table, directed corner cases and a
// randomized run against a timeline model of the glitch pulse sequencer.
module tb_glitch_pulse_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm_i = 1'b0;
   logic        abort_i = 1'b0;
   logic        trigger_i = 1'b0;
   logic [1:0]  edge_sel_i = '0;
   logic [31:0] delay_i = '0;
   logic [15:0] width_i = '0;
   logic [15:0] gap_i = '0;
   logic [7:0]  repeat_i = '0;
   logic        pulse_o, armed_o, busy_o, done_o, timeout_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   glitch_pulse_sequencer #(
      .DELAY_W(32), .WIDTH_W(16), .REP_W(8),
      .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i),
      .trigger_i(trigger_i), .edge_sel_i(edge_sel_i), .delay_i(delay_i),
      .width_i(width_i), .gap_i(gap_i), .repeat_i(repeat_i),
      .pulse_o(pulse_o), .armed_o(armed_o), .busy_o(busy_o),
      .done_o(done_o), .timeout_o(timeout_o)
   );

   typedef struct {
      logic [1:0] sel;
      int d, w, g, r;
      int first, highs, done;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input logic lvl);
      trigger_i = lvl;
      repeat (5) tick();
   endtask

   task automatic arm(input logic [1:0] s, input int d, input int w,
                      input int g, input int r);
      edge_sel_i = s;
      delay_i    = 32'(d);
      width_i    = 16'(w);
      gap_i      = 16'(g);
      repeat_i   = 8'(r);
      arm_i      = 1'b1;
      tick();
      arm_i      = 1'b0;
      edge_sel_i = 2'($urandom);
      delay_i    = $urandom;
      width_i    = 16'($urandom);
      gap_i      = 16'($urandom);
      repeat_i   = 8'($urandom);
   endtask

   // k=0 is the first edge sampling the trigger level set by the caller
   task automatic measure(input int maxc, output int first,
                          output int highs, output int done_at);
      first = -1;
      highs = 0;
      done_at = -1;
      for (int k = 0; k < maxc; k++) begin
         tick();
         if (pulse_o) begin
            if (first < 0) first = k;
            highs++;
         end
         if (done_o && done_at < 0) done_at = k;
         if (done_at >= 0 && k > done_at + 1) break;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f, h, dn, seen, cnt;
      logic lvl[0:127];

      vecs[0] = '{2'b00, 10, 5, 0, 1, 12, 5, 17};
      vecs[1] = '{2'b00, 0, 3, 2, 4, 2, 12, 20};
      vecs[2] = '{2'b10, 1, 0, 0, 0, 3, 1, 4};
      vecs[3] = '{2'b01, 2, 2, 1, 2, 4, 4, 9};
      vecs[4] = '{2'b11, 0, 1, 3, 3, 2, 3, 11};

      #3;
      chk("rst_pulse", int'(pulse_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_armed", int'(armed_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         logic pre;
         pre = (vecs[i].sel == 2'b01);
         settle(pre);
         arm(vecs[i].sel, vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].r);
         repeat (3) tick();
         trigger_i = ~pre;
         measure(80, f, h, dn);
         chk($sformatf("vec%0d_first", i), f, vecs[i].first);
         chk($sformatf("vec%0d_highs", i), h, vecs[i].highs);
         chk($sformatf("vec%0d_done", i), dn, vecs[i].done);
      end

      // rising mode with trigger already high at arm
      settle(1'b1);
      arm(2'b00, 0, 1, 1, 1);
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(pulse_o); end
      chk("hi_at_arm_nopulse", cnt, 0);
      chk("hi_at_arm_armed", int'(armed_o), 1);
      trigger_i = 1'b0;
      repeat (6) begin tick(); cnt += int'(pulse_o); end
      chk("fall_in_rise_mode", cnt, 0);
      trigger_i = 1'b1;
      measure(20, f, h, dn);
      chk("rise_after_fall_first", f, 2);

      // falling mode: rise ignored, fall fires
      settle(1'b0);
      arm(2'b01, 0, 2, 1, 1);
      trigger_i = 1'b1;
      cnt = 0;
      repeat (8) begin tick(); cnt += int'(pulse_o); end
      chk("fall_mode_rise_nopulse", cnt, 0);
      trigger_i = 1'b0;
      measure(20, f, h, dn);
      chk("fall_mode_first", f, 2);
      chk("fall_mode_highs", h, 2);

      // abort during GAP of a repeat=3 train
      settle(1'b0);
      arm(2'b00, 0, 2, 5, 3);
      repeat (3) tick();
      trigger_i = 1'b1;
      repeat (6) tick();
      chk("abort_in_gap_pre", int'(pulse_o), 0);
      chk("abort_in_gap_busy_pre", int'(busy_o), 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_pulse", int'(pulse_o), 0);
      seen = 0;
      repeat (15) begin tick(); seen += int'(pulse_o) + int'(done_o); end
      chk("abort_quiet", seen, 0);

      // arm and abort together
      settle(1'b0);
      arm_i = 1'b1;
      abort_i = 1'b1;
      tick();
      arm_i = 1'b0;
      abort_i = 1'b0;
      chk("arm_abort_armed", int'(armed_o), 0);
      trigger_i = 1'b1;
      seen = 0;
      repeat (8) begin tick(); seen += int'(pulse_o) + int'(busy_o); end
      chk("arm_abort_idle", seen, 0);

      // retrigger in DELAY and arm while busy both ignored
      settle(1'b0);
      arm(2'b10, 8, 2, 1, 1);
      repeat (3) tick();
      trigger_i = 1'b1;
      repeat (3) tick();
      trigger_i = 1'b0;
      tick();
      trigger_i = 1'b1;
      edge_sel_i = 2'b00;
      delay_i = 0;
      width_i = 6;
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      measure(40, f, h, dn);
      chk("busy_arm_first", f, 5);
      chk("busy_arm_highs", h, 2);
      chk("busy_arm_done", dn, 7);

      // reset mid-pulse
      settle(1'b0);
      arm(2'b00, 2, 20, 1, 1);
      repeat (3) tick();
      trigger_i = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (pulse_o) begin seen = 1; break; end
      end
      chk("rst_mid_reached", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_pulse", int'(pulse_o), 0);
      chk("rst_mid_busy", int'(busy_o), 0);
      chk("rst_mid_done", int'(done_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      seen = 0;
      repeat (8) begin tick(); seen += int'(pulse_o) + int'(busy_o); end
      chk("rst_mid_idle", seen, 0);

      // arm-to-trigger timeout
      settle(1'b0);
      arm(2'b00, 0, 1, 1, 1);
      f = -1;
      seen = 0;
      for (int k = 1; k <= 150; k++) begin
         tick();
         if (timeout_o && f < 0) f = k;
         seen += int'(done_o);
      end
`ifdef GLITCH_TRIG_TIMEOUT_EN
      chk("timeout_at", f, 100);
      chk("timeout_armed_after", int'(armed_o), 0);
`else
      chk("no_timeout", f, -1);
      chk("still_armed", int'(armed_o), 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
`endif
      chk("timeout_no_done", seen, 0);

      // randomized runs against a timeline model
      for (int it = 0; it < 20; it++) begin
         logic [1:0] sel;
         logic l0;
         int d, w, g, r, n, ww, gg, t, p0, j, ntog;
         int exp_v, act_v;
         sel = 2'($urandom);
         d = $urandom % 7;
         w = $urandom % 5;
         g = $urandom % 5;
         r = $urandom % 5;
         l0 = 1'($urandom);
         for (int m = 0; m < 128; m++) lvl[m] = l0;
         j = 3 + $urandom % 4;
         ntog = 2 + $urandom % 3;
         for (int q = 0; q < ntog; q++) begin
            for (int m = j; m < 128; m++) lvl[m] = ~lvl[m];
            j += 1 + $urandom % 6;
         end
         t = -1;
         for (int m = 3; m < 128; m++) begin
            if (t < 0 && lvl[m] != lvl[m-1]) begin
               if (sel == 2'b10 || (sel == 2'b01) == !lvl[m]) t = m;
            end
         end
         n = (r == 0) ? 1 : r;
         ww = (w == 0) ? 1 : w;
         gg = (g == 0) ? 1 : g;
         p0 = t + 2 + d;
         dn = p0 + n * ww + (n - 1) * gg;
         settle(l0);
         edge_sel_i = sel;
         delay_i = 32'(d);
         width_i = 16'(w);
         gap_i = 16'(g);
         repeat_i = 8'(r);
         for (int k = 0; k <= dn + 2; k++) begin
            logic ep;
            trigger_i = lvl[k];
            arm_i = (k == 0);
            tick();
            arm_i = 1'b0;
            edge_sel_i = 2'($urandom);
            delay_i = $urandom;
            width_i = 16'($urandom);
            ep = 1'b0;
            for (int i = 0; i < n; i++) begin
               if (k >= p0 + i * (ww + gg) && k < p0 + i * (ww + gg) + ww)
                  ep = 1'b1;
            end
            exp_v = {ep, (k < dn), (k <= t + 1), (k == dn)};
            act_v = {pulse_o, busy_o, armed_o, done_o};
            chk($sformatf("rand%0d_c%0d", it, k), act_v, exp_v);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
